// File: rtl/usb_tx_encoder.sv
// USB full-speed serializer: SYNC, LSB-first data with bit stuffing, NRZI, EOP; first K one cycle after the first accept.
// Backpressure: one-byte holding register, tx_ready drops while it is full or once the last byte is taken.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic [2:0]      ones_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            shift_last;
    logic [7:0]      hold_data;
    logic            hold_last;
    logic            hold_full;
    logic            last_accepted;
    logic            err_flag;
    logic            level;

    logic            bit_end;
    logic            xfer;
    logic            send_vld;
    logic            send_bit;
    logic            load_shift;
    logic            advance;
    logic            stuff_now;
    logic            level_nxt;
    logic            dp_nxt;
    logic            dm_nxt;

    assign bit_end = (timer == TW'(CLKS_PER_BIT - 1));
    assign xfer    = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bit-boundary decode. shift_reg holds only the bits still to be sent,
    // so its bit 0 is always the next data bit.
    always_comb begin
        send_vld   = 1'b0;
        send_bit   = 1'b0;
        load_shift = 1'b0;
        advance    = 1'b0;
        stuff_now  = 1'b0;
        if (bit_end) begin
            case (state)
                SYNC: begin
                    if (bit_idx != 3'd7) begin
                        send_vld = 1'b1;
                        send_bit = (bit_idx == 3'd6);
                    end else if (hold_full) begin
                        load_shift = 1'b1;
                        send_vld   = 1'b1;
                        send_bit   = hold_data[0];
                    end
                end
                DATA: begin
                    if (ones_cnt == 3'd6) begin
                        stuff_now = 1'b1;
                    end else if (bit_idx != 3'd7) begin
                        advance  = 1'b1;
                        send_vld = 1'b1;
                        send_bit = shift_reg[0];
                    end else if (!shift_last && hold_full) begin
                        load_shift = 1'b1;
                        send_vld   = 1'b1;
                        send_bit   = hold_data[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = SYNC;
            SYNC:    if (bit_end && bit_idx == 3'd7) state_nxt = hold_full ? DATA : EOP_SE0;
            DATA:    if (bit_end && !stuff_now && bit_idx == 3'd7 && !load_shift) state_nxt = EOP_SE0;
            EOP_SE0: if (bit_end && bit_idx == 3'd1) state_nxt = EOP_J;
            EOP_J:   if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (state == IDLE && xfer)
            level_nxt = 1'b0;
        else if ((send_vld && !send_bit) || stuff_now)
            level_nxt = ~level;

        case (state_nxt)
            SYNC, DATA: begin dp_nxt = level_nxt; dm_nxt = ~level_nxt; end
            EOP_SE0:    begin dp_nxt = 1'b0;      dm_nxt = 1'b0;       end
            default:    begin dp_nxt = 1'b1;      dm_nxt = 1'b0;       end
        endcase

        tx_active = (state != IDLE);
        tx_ready  = ~hold_full & ~last_accepted &
                    ((state == IDLE) || (state == SYNC) || (state == DATA));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer         <= '0;
            ones_cnt      <= 3'd0;
            bit_idx       <= 3'd0;
            shift_reg     <= 8'd0;
            shift_last    <= 1'b0;
            hold_data     <= 8'd0;
            hold_last     <= 1'b0;
            hold_full     <= 1'b0;
            last_accepted <= 1'b0;
            err_flag      <= 1'b0;
            level         <= 1'b1;
            d_plus        <= 1'b1;
            d_minus       <= 1'b0;
            tx_done       <= 1'b0;
            tx_error      <= 1'b0;
        end else begin
            level    <= level_nxt;
            d_plus   <= dp_nxt;
            d_minus  <= dm_nxt;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            timer    <= (state == IDLE || bit_end) ? '0 : timer + TW'(1);

            // The accepting edge already puts SYNC bit 0 (a zero) on the line.
            if (state == IDLE && xfer) begin
                ones_cnt <= 3'd0;
                bit_idx  <= 3'd0;
            end
            if (send_vld)  ones_cnt <= send_bit ? ones_cnt + 3'd1 : 3'd0;
            if (stuff_now) ones_cnt <= 3'd0;

            if (load_shift) begin
                shift_reg  <= {1'b0, hold_data[7:1]};
                shift_last <= hold_last;
                bit_idx    <= 3'd0;
            end else if (advance || (state == SYNC && send_vld)) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (advance) shift_reg <= {1'b0, shift_reg[7:1]};

            if (state != EOP_SE0 && state_nxt == EOP_SE0) begin
                bit_idx <= 3'd0;
                if (!(state == DATA && shift_last)) err_flag <= 1'b1;
            end else if (state == EOP_SE0 && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (load_shift) hold_full <= 1'b0;
            if (xfer) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
                if (tx_last) last_accepted <= 1'b1;
            end

            if (state == EOP_J && bit_end) begin
                tx_done       <= 1'b1;
                tx_error      <= err_flag;
                err_flag      <= 1'b0;
                last_accepted <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line levels per bit time, handshake timing, done/error pulses, resets.
module tb_usb_tx_encoder;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    int n_assert = 0;
    int n_fail   = 0;
    int ready_at;
    int bad;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One letter per bit time: J, K, S = SE0, e = EOP J (line J, tx_ready must be low).
    task automatic check_bits(input string tag, input string seq);
        for (int b = 0; b < seq.len(); b++) begin
            logic [1:0] want;
            logic       rdy_low;
            int         nbad;
            nbad    = 0;
            rdy_low = (seq[b] == "S" || seq[b] == "e");
            want    = (seq[b] == "K") ? 2'b01 : (seq[b] == "S") ? 2'b00 : 2'b10;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if ({d_plus, d_minus} !== want || tx_active !== 1'b1 || tx_done !== 1'b0 ||
                    (rdy_low && tx_ready !== 1'b0))
                    nbad++;
            end
            chk($sformatf("%s bit%0d bad_cycles(want line %b)", tag, b, want), nbad, 0);
        end
    endtask

    task automatic check_end(input string tag, input logic exp_err);
        @(negedge clk);
        chk({tag, " tx_done"}, tx_done, 1'b1);
        chk({tag, " tx_error"}, tx_error, exp_err);
        chk({tag, " idle_line"}, {d_plus, d_minus}, 2'b10);
        chk({tag, " tx_active"}, tx_active, 1'b0);
    endtask

    task automatic start_packet(input logic [7:0] d, input logic last);
        @(negedge clk);
        chk("ready_in_idle", tx_ready, 1'b1);
        chk("done_cleared", tx_done, 1'b0);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = last;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst d_plus", d_plus, 1'b1);
        chk("rst d_minus", d_minus, 1'b0);
        chk("rst tx_ready", tx_ready, 1'b1);
        chk("rst tx_active", tx_active, 1'b0);
        chk("rst tx_done", tx_done, 1'b0);
        chk("rst tx_error", tx_error, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_rst line", {d_plus, d_minus}, 2'b10);
        chk("idle_rst tx_ready", tx_ready, 1'b1);
        chk("idle_rst tx_active", tx_active, 1'b0);
        chk("idle_rst tx_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_packet(8'h00, 1'b1);
        check_bits("b00", "KJKJKJKKJKJKJKJKSSe");
        check_end("b00", 1'b0);

        start_packet(8'hFF, 1'b1);
        check_bits("bFF", "KJKJKJKKKKKKKJJJJSSe");
        check_end("bFF", 1'b0);

        // Two bytes, tx_valid held high; second byte waits in the holding register.
        @(negedge clk);
        chk("ready_before_3C", tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tx_last  = 1'b0;
        @(posedge clk);
        #1;
        tx_data = 8'hA5;
        tx_last = 1'b1;
        fork
            begin
                int n;
                ready_at = 0;
                n = 0;
                while (ready_at == 0 && n < 200) begin
                    n++;
                    @(negedge clk);
                    if (tx_ready === 1'b1) ready_at = n;
                end
                if (ready_at != 0) @(posedge clk);
                #1;
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
            check_bits("b3CA5", "KJKJKJKKJKKKKKJKKJJKJJKKSSe");
        join
        chk("ready_rise_cycle", ready_at, 65);
        check_end("b3CA5", 1'b0);

        start_packet(8'h01, 1'b0);
        check_bits("underrun", "KJKJKJKKKJKJKJKJSSe");
        check_end("underrun", 1'b1);

        // Reset in the third data bit of 0x55.
        start_packet(8'h55, 1'b1);
        check_bits("b55", "KJKJKJKKKJ");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst line", {d_plus, d_minus}, 2'b10);
        chk("midrst tx_active", tx_active, 1'b0);
        chk("midrst tx_ready", tx_ready, 1'b1);
        chk("midrst tx_done", tx_done, 1'b0);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_active !== 1'b0 || {d_plus, d_minus} !== 2'b10) bad++;
        end
        chk("post_rst_quiet bad_cycles", bad, 0);

        start_packet(8'h00, 1'b1);
        check_bits("restart", "KJKJKJKKJKJKJKJKSSe");
        check_end("restart", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
